// File: rtl/rca_seq_wide_adder_if.sv
// Operand/result bundle for rca_seq_wide_adder.
//   in_valid/in_ready  operand handshake (producer -> adder)
//   a, b, cin          operands and carry into chunk 0
//   out_valid/out_ready result handshake (adder -> consumer)
//   sum, cout          registered result and carry out of the top bit
//   busy               adder is working on or holding a result
//   ovf                signed overflow of the result (only with RCA_SEQ_OVF_EN)
// master: producer/consumer side. slave: the adder.
interface rca_seq_wide_adder_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef RCA_SEQ_OVF_EN
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy, ovf
    );
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy, ovf
    );
`else
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/rca_seq_wide_adder.sv
// Multi-cycle wide adder: one CHUNK-bit gate-level ripple-carry slice is reused
// WIDTH/CHUNK times, least-significant chunk first, with a registered carry
// between passes.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-high
//   bus  rca_seq_wide_adder_if.slave (in_valid/in_ready, a, b, cin,
//        out_valid/out_ready, sum, cout, busy[, ovf])
// Configuration macro: RCA_SEQ_OVF_EN adds bus.ovf, the two's-complement
// overflow of the most-significant chunk (carry into MSB xor carry out of MSB).
// WIDTH must be a multiple of CHUNK; CHUNK must be a multiple of 4 and >= 4.
module rca_seq_wide_adder #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input logic                 clk,
    input logic                 rst,
    rca_seq_wide_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    idx;
    logic             carry_q;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic [CHUNK-1:0] op_a;
    logic [CHUNK-1:0] op_b;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             accept;
    logic             last_chunk;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             busy_c;
`ifdef RCA_SEQ_OVF_EN
    logic             slice_msb_cin;
    logic             ovf_q;
`endif

    assign op_a = a_reg[idx*CHUNK +: CHUNK];
    assign op_b = b_reg[idx*CHUNK +: CHUNK];

    // Gate-level ripple-carry slice; each bit keeps its own carry so the
    // chain is a plain series of full adders.
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
        logic ci;
        logic p;
        logic co;
        if (gi == 0) begin : g_first
            assign ci = carry_q;
        end else begin : g_next
            assign ci = g_fa[gi-1].co;
        end
        assign p             = op_a[gi] ^ op_b[gi];
        assign slice_sum[gi] = p ^ ci;
        assign co            = (op_a[gi] & op_b[gi]) | (ci & p);
    end

    assign slice_cout = g_fa[CHUNK-1].co;
`ifdef RCA_SEQ_OVF_EN
    assign slice_msb_cin = g_fa[CHUNK-1].ci;
`endif

    assign accept     = (state == IDLE) && bus.in_valid;
    assign last_chunk = (idx == CW'(NCHUNK - 1));

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy_c = 1'b1;
                if (last_chunk) state_nxt = DONE;
            end
            DONE: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand capture; contents are irrelevant until the next accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
        end
    end

    // Chunk sequencing and result assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (accept) begin
            idx     <= '0;
            carry_q <= bus.cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (state == RUN) begin
            sum_q[idx*CHUNK +: CHUNK] <= slice_sum;
            carry_q                   <= slice_cout;
            idx                       <= last_chunk ? '0 : idx + 1'b1;
            if (last_chunk) begin
                cout_q <= slice_cout;
`ifdef RCA_SEQ_OVF_EN
                ovf_q  <= slice_cout ^ slice_msb_cin;
`endif
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef RCA_SEQ_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule
